// File: rtl/common.sv
// Shared global-buffer types: instruction encoding and sequencer states.
package common;

    typedef enum logic [3:0] {
        I_NOP             = 4'd0,
        I_POINTER_RESET   = 4'd1,
        I_LOAD_WEIGHT     = 4'd2,
        I_LOAD_ACTIVATION = 4'd3,
        I_LOAD_OUTPUT     = 4'd4,
        I_READ_ACTIVATION = 4'd5
    } global_buffer_instruction_t;

    typedef enum logic [2:0] {
        GBS_IDLE    = 3'd0,
        GBS_PTR_RST = 3'd1,
        GBS_WRITE   = 3'd2,
        GBS_READ    = 3'd3,
        GBS_DONE    = 3'd4
    } gbs_state_t;

    // Opcodes at or above this value are illegal.
    localparam int unsigned GBS_NUM_OPCODES = 6;

endpackage

// File: rtl/gbs_out_reg.sv
// Single-entry valid/ready holding register for the read stream.
// A load while full and not draining is dropped and flagged on overflow_c.
module gbs_out_reg #(
    parameter int unsigned dataWidth = 128
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 load_i,
    input  logic [dataWidth-1:0] data_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [dataWidth-1:0] data_o,
    output logic                 overflow_c
);

    logic blocked_c;

    assign blocked_c  = valid_o && !ready_i;
    assign overflow_c = load_i && blocked_c;

    // Load when the slot is free or draining this cycle; otherwise clear on drain.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (load_i && !blocked_c) begin
            valid_o <= 1'b1;
            data_o  <= data_i;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/global_buffer_sequencer.sv
// Command-driven sequencer for the global buffer: decodes one command at a
// time, drives the buffer instruction and start addresses, and bridges the
// write stream into the buffer and buffer read data out to the read stream.
module global_buffer_sequencer
    import common::*;
#(
    parameter int unsigned addrWidth      = 32,
    parameter int unsigned dataSize       = 8,
    parameter int unsigned interfaceDepth = 16,
    parameter int unsigned countWidth     = 16
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic                                 cmd_valid_i,
    output logic                                 cmd_ready_o,
    input  logic [3:0]                           cmd_instr_i,
    input  logic [addrWidth-1:0]                 cmd_addr_i,
    input  logic [countWidth-1:0]                cmd_count_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [interfaceDepth*dataSize-1:0]   in_data_i,
    output logic [3:0]                           buf_instr_o,
    input  logic                                 buf_ready_i,
    output logic [interfaceDepth*dataSize-1:0]   buf_wr_data_o,
    output logic                                 buf_wr_en_o,
    input  logic [interfaceDepth*dataSize-1:0]   buf_rd_data_i,
    input  logic                                 buf_rd_data_valid_i,
    output logic [addrWidth-1:0]                 weight_start_addr_o,
    output logic [addrWidth-1:0]                 activation_start_addr_o,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [interfaceDepth*dataSize-1:0]   out_data_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 err_o
);

    localparam int unsigned interfaceWidth = interfaceDepth * dataSize;

    gbs_state_t            state_q, state_d;
    logic [countWidth-1:0] cnt_q, cnt_d;
    logic [3:0]            op_q, op_d;
    logic [addrWidth-1:0]  waddr_q, waddr_d;
    logic [addrWidth-1:0]  aaddr_q, aaddr_d;
    logic                  err_q, err_d;

    logic                  overflow_c;
    logic                  rd_load_c;
    logic                  read_blocked_c;
    logic                  cmd_zero_c;
    logic                  cmd_bad_c;

    assign weight_start_addr_o     = waddr_q;
    assign activation_start_addr_o = aaddr_q;
    assign err_o                   = err_q;

    // A new read must wait until the previous read's last word has drained.
    assign read_blocked_c = (cmd_instr_i == I_READ_ACTIVATION) && out_valid_o;
    assign cmd_zero_c     = (cmd_count_i == '0);
    assign cmd_bad_c      = (32'(cmd_instr_i) >= GBS_NUM_OPCODES);
    assign rd_load_c      = (state_q == GBS_READ) && buf_rd_data_valid_i;

    // Read-stream holding register.
    gbs_out_reg #(
        .dataWidth(interfaceWidth)
    ) u_out_reg (
        .clk        (clk),
        .nrst       (nrst),
        .load_i     (rd_load_c),
        .data_i     (buf_rd_data_i),
        .ready_i    (out_ready_i),
        .valid_o    (out_valid_o),
        .data_o     (out_data_o),
        .overflow_c (overflow_c)
    );

    // Sequencer state, word counter, latched opcode, addresses and sticky error.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= GBS_IDLE;
            cnt_q   <= '0;
            op_q    <= I_NOP;
            waddr_q <= '0;
            aaddr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            waddr_q <= waddr_d;
            aaddr_q <= aaddr_d;
            err_q   <= err_d;
        end
    end

    // Next-state decode and per-state handshake/buffer outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        waddr_d       = waddr_q;
        aaddr_d       = aaddr_q;
        err_d         = err_q | overflow_c;
        cmd_ready_o   = 1'b0;
        in_ready_o    = 1'b0;
        buf_wr_en_o   = 1'b0;
        buf_wr_data_o = '0;
        buf_instr_o   = I_NOP;
        busy_o        = (state_q != GBS_IDLE);
        done_o        = 1'b0;

        case (state_q)
            GBS_IDLE: begin
                cmd_ready_o = !read_blocked_c;
                if (cmd_valid_i && !read_blocked_c) begin
                    cnt_d = cmd_count_i;
                    op_d  = cmd_instr_i;
                    if (cmd_bad_c) begin
                        err_d   = 1'b1;
                        state_d = GBS_DONE;
                    end else begin
                        case (cmd_instr_i)
                            I_POINTER_RESET: state_d = GBS_PTR_RST;
                            I_LOAD_WEIGHT: begin
                                waddr_d = cmd_addr_i;
                                state_d = cmd_zero_c ? GBS_DONE : GBS_WRITE;
                            end
                            I_LOAD_ACTIVATION, I_LOAD_OUTPUT: begin
                                aaddr_d = cmd_addr_i;
                                state_d = cmd_zero_c ? GBS_DONE : GBS_WRITE;
                            end
                            I_READ_ACTIVATION: begin
                                aaddr_d = cmd_addr_i;
                                state_d = cmd_zero_c ? GBS_DONE : GBS_READ;
                            end
                            default: state_d = GBS_DONE;
                        endcase
                    end
                end
            end

            GBS_PTR_RST: begin
                buf_instr_o = I_POINTER_RESET;
                state_d     = GBS_DONE;
            end

            GBS_WRITE: begin
                buf_instr_o   = op_q;
                buf_wr_data_o = in_data_i;
                buf_wr_en_o   = in_valid_i;
                in_ready_o    = buf_ready_i;
                if (in_valid_i && buf_ready_i) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - countWidth'(1);
                    end
                    if (cnt_q <= countWidth'(1)) begin
                        state_d = GBS_DONE;
                    end
                end
            end

            GBS_READ: begin
                // Hold the buffer off while the output slot is stalled.
                buf_instr_o = (out_valid_o && !out_ready_i) ? 4'(I_NOP) : op_q;
                if (rd_load_c) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - countWidth'(1);
                    end
                    if (cnt_q <= countWidth'(1)) begin
                        state_d = GBS_DONE;
                    end
                end
            end

            GBS_DONE: begin
                done_o  = 1'b1;
                state_d = GBS_IDLE;
            end

            default: state_d = GBS_IDLE;
        endcase
    end

endmodule

// File: tb/tb_global_buffer_sequencer.sv
// Scenario bench for global_buffer_sequencer with a data scoreboard queue.
module tb_global_buffer_sequencer;

    logic         clk;
    logic         nrst;
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic [3:0]   cmd_instr_i;
    logic [31:0]  cmd_addr_i;
    logic [15:0]  cmd_count_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] in_data_i;
    logic [3:0]   buf_instr_o;
    logic         buf_ready_i;
    logic [127:0] buf_wr_data_o;
    logic         buf_wr_en_o;
    logic [127:0] buf_rd_data_i;
    logic         buf_rd_data_valid_i;
    logic [31:0]  weight_start_addr_o;
    logic [31:0]  activation_start_addr_o;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] out_data_o;
    logic         busy_o;
    logic         done_o;
    logic         err_o;

    logic [127:0] exp_q[$];
    int           n_checks;
    int           n_fail;

    global_buffer_sequencer dut (
        .clk                     (clk),
        .nrst                    (nrst),
        .cmd_valid_i             (cmd_valid_i),
        .cmd_ready_o             (cmd_ready_o),
        .cmd_instr_i             (cmd_instr_i),
        .cmd_addr_i              (cmd_addr_i),
        .cmd_count_i             (cmd_count_i),
        .in_valid_i              (in_valid_i),
        .in_ready_o              (in_ready_o),
        .in_data_i               (in_data_i),
        .buf_instr_o             (buf_instr_o),
        .buf_ready_i             (buf_ready_i),
        .buf_wr_data_o           (buf_wr_data_o),
        .buf_wr_en_o             (buf_wr_en_o),
        .buf_rd_data_i           (buf_rd_data_i),
        .buf_rd_data_valid_i     (buf_rd_data_valid_i),
        .weight_start_addr_o     (weight_start_addr_o),
        .activation_start_addr_o (activation_start_addr_o),
        .out_valid_o             (out_valid_o),
        .out_ready_i             (out_ready_i),
        .out_data_o              (out_data_o),
        .busy_o                  (busy_o),
        .done_o                  (done_o),
        .err_o                   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid_i         = 1'b0;
        cmd_instr_i         = 4'd0;
        cmd_addr_i          = 32'd0;
        cmd_count_i         = 16'd0;
        in_valid_i          = 1'b0;
        in_data_i           = 128'd0;
        buf_ready_i         = 1'b0;
        buf_rd_data_i       = 128'd0;
        buf_rd_data_valid_i = 1'b0;
        out_ready_i         = 1'b0;
    endtask

    // Present a command and hold it until accepted (bounded).
    task automatic send_cmd(input logic [3:0] instr, input logic [31:0] addr,
                            input logic [15:0] count);
        bit ok;
        ok          = 1'b0;
        cmd_instr_i = instr;
        cmd_addr_i  = addr;
        cmd_count_i = count;
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            ok = cmd_ready_o;
            step();
        end
        cmd_valid_i = 1'b0;
        cmd_instr_i = 4'd0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL cmd_accept: instr=%0d not accepted within 20 cycles", instr);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        nrst = 1'b0;
        step();
        step();
        n_checks++;
        if ({busy_o, cmd_ready_o, out_valid_o, err_o, done_o, in_ready_o, buf_wr_en_o} !== 7'b0100000) begin
            n_fail++;
            $display("FAIL reset_flags: busy,rdy,oval,err,done,inrdy,wren got %b exp 0100000",
                     {busy_o, cmd_ready_o, out_valid_o, err_o, done_o, in_ready_o, buf_wr_en_o});
        end
        n_checks++;
        if (buf_instr_o !== 4'd0 || weight_start_addr_o !== 32'd0 ||
            activation_start_addr_o !== 32'd0 || out_data_o !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_values: instr=%0d waddr=%h aaddr=%h out=%h exp all 0",
                     buf_instr_o, weight_start_addr_o, activation_start_addr_o, out_data_o);
        end
        nrst = 1'b1;
        step();
    endtask

    task automatic test_pointer_reset();
        send_cmd(4'd1, 32'd0, 16'd0);
        n_checks++;
        if (buf_instr_o !== 4'd1 || busy_o !== 1'b1 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ptr_rst_pulse: instr=%0d busy=%b done=%b exp 1 1 0", buf_instr_o, busy_o, done_o);
        end
        step();
        n_checks++;
        if (buf_instr_o !== 4'd0 || done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ptr_rst_done: instr=%0d done=%b exp 0 1", buf_instr_o, done_o);
        end
        step();
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ptr_rst_idle: busy=%b done=%b rdy=%b exp 0 0 1", busy_o, done_o, cmd_ready_o);
        end
    endtask

    task automatic test_load_weight();
        int           rem;
        logic         rdy;
        logic [127:0] exp;
        rem = 4;
        rdy = 1'b1;
        send_cmd(4'd2, 32'h100, 16'd4);
        n_checks++;
        if (weight_start_addr_o !== 32'h100 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL lw_addr: waddr=%h busy=%b exp 00000100 1", weight_start_addr_o, busy_o);
        end
        for (int cyc = 0; cyc < 40 && rem > 0; cyc++) begin
            in_valid_i  = 1'b1;
            in_data_i   = {$urandom(), $urandom(), $urandom(), $urandom()};
            buf_ready_i = rdy;
            if (rdy) exp_q.push_back(in_data_i);
            #1;
            n_checks++;
            if (buf_wr_en_o !== 1'b1 || in_ready_o !== rdy || buf_instr_o !== 4'd2 || done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL lw_handshake: cyc=%0d wren=%b inrdy=%b instr=%0d done=%b exp 1 %b 2 0",
                         cyc, buf_wr_en_o, in_ready_o, buf_instr_o, done_o, rdy);
            end
            if (rdy) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (buf_wr_data_o !== exp) begin
                    n_fail++;
                    $display("FAIL lw_data: got %h exp %h", buf_wr_data_o, exp);
                end
                rem--;
            end
            step();
            rdy = !rdy;
        end
        buf_ready_i = 1'b1;
        #1;
        n_checks++;
        if (done_o !== 1'b1 || in_ready_o !== 1'b0 || buf_wr_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_done: done=%b inrdy=%b wren=%b exp 1 0 0", done_o, in_ready_o, buf_wr_en_o);
        end
        step();
        n_checks++;
        if (busy_o !== 1'b0 || in_ready_o !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL lw_after: busy=%b inrdy=%b pending=%0d exp 0 0 0", busy_o, in_ready_o, exp_q.size());
        end
        in_valid_i  = 1'b0;
        buf_ready_i = 1'b0;
    endtask

    task automatic test_read();
        int           sent;
        int           n_out;
        int           done_seen;
        logic [127:0] exp;
        logic [127:0] words [3];
        words[0]  = 128'hA;
        words[1]  = 128'hB;
        words[2]  = 128'hC;
        sent      = 0;
        n_out     = 0;
        done_seen = 0;
        out_ready_i = 1'b1;
        send_cmd(4'd5, 32'h40, 16'd3);
        n_checks++;
        if (activation_start_addr_o !== 32'h40 || buf_instr_o !== 4'd5) begin
            n_fail++;
            $display("FAIL rd_start: aaddr=%h instr=%0d exp 00000040 5", activation_start_addr_o, buf_instr_o);
        end
        for (int cyc = 0; cyc < 30 && !(n_out == 3 && sent == 3); cyc++) begin
            if (out_valid_o) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (out_data_o !== exp) begin
                    n_fail++;
                    $display("FAIL rd_data: word %0d got %h exp %h", n_out, out_data_o, exp);
                end
                n_out++;
            end
            if (done_o) done_seen++;
            if (sent < 3 && cyc != 1) begin
                buf_rd_data_valid_i = 1'b1;
                buf_rd_data_i       = words[sent];
                exp_q.push_back(words[sent]);
                sent++;
            end else begin
                buf_rd_data_valid_i = 1'b0;
            end
            step();
        end
        buf_rd_data_valid_i = 1'b0;
        n_checks++;
        if (n_out != 3 || done_seen != 1 || err_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_summary: words=%0d done=%0d err=%b busy=%b exp 3 1 0 0",
                     n_out, done_seen, err_o, busy_o);
        end
    endtask

    task automatic test_read_overflow();
        logic [127:0] exp;
        out_ready_i = 1'b0;
        send_cmd(4'd5, 32'h80, 16'd2);
        buf_rd_data_valid_i = 1'b1;
        buf_rd_data_i       = 128'h1111;
        exp_q.push_back(128'h1111);
        step();
        buf_rd_data_i = 128'h2222;
        #1;
        n_checks++;
        if (out_valid_o !== 1'b1 || buf_instr_o !== 4'd0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_stall: oval=%b instr=%0d err=%b exp 1 0 0", out_valid_o, buf_instr_o, err_o);
        end
        step();
        buf_rd_data_valid_i = 1'b0;
        n_checks++;
        if (err_o !== 1'b1 || done_o !== 1'b1 || out_data_o !== exp_q[0]) begin
            n_fail++;
            $display("FAIL ovf_drop: err=%b done=%b out=%h exp 1 1 %h", err_o, done_o, out_data_o, exp_q[0]);
        end
        step();
        cmd_instr_i = 4'd5;
        #1;
        n_checks++;
        if (cmd_ready_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_read_wait: rdy=%b busy=%b exp 0 0", cmd_ready_o, busy_o);
        end
        cmd_instr_i = 4'd0;
        #1;
        n_checks++;
        if (cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_other_ok: rdy=%b exp 1", cmd_ready_o);
        end
        out_ready_i = 1'b1;
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== exp) begin
            n_fail++;
            $display("FAIL ovf_drain: oval=%b out=%h exp 1 %h", out_valid_o, out_data_o, exp);
        end
        step();
        step();
        step();
        n_checks++;
        if (out_valid_o !== 1'b0 || err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: oval=%b err=%b exp 0 1", out_valid_o, err_o);
        end
    endtask

    task automatic test_bad_opcode();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        n_checks++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_pre_err: err=%b exp 0", err_o);
        end
        in_valid_i  = 1'b1;
        buf_ready_i = 1'b1;
        send_cmd(4'd9, 32'h55, 16'd3);
        n_checks++;
        if (done_o !== 1'b1 || err_o !== 1'b1 || buf_wr_en_o !== 1'b0 ||
            weight_start_addr_o !== 32'd0 || activation_start_addr_o !== 32'd0) begin
            n_fail++;
            $display("FAIL bad_opcode: done=%b err=%b wren=%b waddr=%h aaddr=%h exp 1 1 0 0 0",
                     done_o, err_o, buf_wr_en_o, weight_start_addr_o, activation_start_addr_o);
        end
        step();
        n_checks++;
        if (busy_o !== 1'b0 || err_o !== 1'b1 || buf_wr_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_after: busy=%b err=%b wren=%b exp 0 1 0", busy_o, err_o, buf_wr_en_o);
        end
    endtask

    task automatic test_zero_count();
        in_valid_i  = 1'b1;
        buf_ready_i = 1'b1;
        send_cmd(4'd3, 32'h200, 16'd0);
        n_checks++;
        if (done_o !== 1'b1 || activation_start_addr_o !== 32'h200 ||
            buf_wr_en_o !== 1'b0 || in_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_count: done=%b aaddr=%h wren=%b inrdy=%b exp 1 00000200 0 0",
                     done_o, activation_start_addr_o, buf_wr_en_o, in_ready_o);
        end
        step();
        n_checks++;
        if (busy_o !== 1'b0 || buf_wr_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after: busy=%b wren=%b exp 0 0", busy_o, buf_wr_en_o);
        end
        in_valid_i  = 1'b0;
        buf_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        send_cmd(4'd2, 32'h300, 16'd5);
        in_valid_i  = 1'b1;
        buf_ready_i = 1'b1;
        step();
        step();
        n_checks++;
        if (busy_o !== 1'b1 || buf_wr_en_o !== 1'b1 || weight_start_addr_o !== 32'h300) begin
            n_fail++;
            $display("FAIL mid_write: busy=%b wren=%b waddr=%h exp 1 1 00000300",
                     busy_o, buf_wr_en_o, weight_start_addr_o);
        end
        nrst       = 1'b0;
        in_valid_i = 1'b0;
        step();
        n_checks++;
        if (busy_o !== 1'b0 || buf_instr_o !== 4'd0 || cmd_ready_o !== 1'b1 || err_o !== 1'b0 ||
            weight_start_addr_o !== 32'd0 || activation_start_addr_o !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b instr=%0d rdy=%b err=%b waddr=%h aaddr=%h exp 0 0 1 0 0 0",
                     busy_o, buf_instr_o, cmd_ready_o, err_o, weight_start_addr_o, activation_start_addr_o);
        end
        nrst        = 1'b1;
        buf_ready_i = 1'b0;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nrst     = 1'b0;
        idle_inputs();
        test_reset();
        test_pointer_reset();
        test_load_weight();
        test_read();
        test_read_overflow();
        test_bad_opcode();
        test_zero_count();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
